// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the Beta pipeline datapath and its central sequencer.
// The master drives stage status. The slave (pipe_ctrl) returns stall, IR-source, bypass and PC controls.
interface pipe_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             dec_ra;
  logic [4:0]             dec_rb;
  logic                   dec_use_a;
  logic                   dec_use_b;
  logic                   dec_branch_taken;
  logic                   dec_jmp;
  logic                   dec_illop;
  logic [4:0]             exec_rc;
  logic                   exec_wr;
  logic                   exec_is_ld;
  logic [4:0]             mem_rc;
  logic                   mem_wr;
  logic                   mem_is_ld;
  logic                   mem_is_memop;
  logic                   dmem_ready;
  logic [4:0]             wb_rc;
  logic                   wb_wr;
  logic                   irq;
  logic                   pc_super;

  logic                   stall_if;
  logic                   stall_dec;
  logic                   stall_exec;
  logic                   stall_mem;
  logic [1:0]             ir_src_dec;
  logic [1:0]             ir_src_exec;
  logic [1:0]             bypass_a_sel;
  logic [1:0]             bypass_b_sel;
  logic [2:0]             pc_sel;
  logic                   irq_ack;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output dec_ra, dec_rb, dec_use_a, dec_use_b, dec_branch_taken, dec_jmp, dec_illop,
           exec_rc, exec_wr, exec_is_ld, mem_rc, mem_wr, mem_is_ld, mem_is_memop,
           dmem_ready, wb_rc, wb_wr, irq, pc_super,
    input  stall_if, stall_dec, stall_exec, stall_mem, ir_src_dec, ir_src_exec,
           bypass_a_sel, bypass_b_sel, pc_sel, irq_ack, stall_cnt
  );

  modport slave (
    input  dec_ra, dec_rb, dec_use_a, dec_use_b, dec_branch_taken, dec_jmp, dec_illop,
           exec_rc, exec_wr, exec_is_ld, mem_rc, mem_wr, mem_is_ld, mem_is_memop,
           dmem_ready, wb_rc, wb_wr, irq, pc_super,
    output stall_if, stall_dec, stall_exec, stall_mem, ir_src_dec, ir_src_exec,
           bypass_a_sel, bypass_b_sel, pc_sel, irq_ack, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage Beta pipeline: stalls, NOP/exception injection,
// operand bypass, PC source, data-memory wait FSM, interrupt latch and stall counter.
module pipe_ctrl #(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [4:0]  NREG_ZERO   = 5'd31
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    RUN,
    MWAIT
  } fsm_t;

  typedef enum logic [1:0] {
    IR_DATA   = 2'd0,
    IR_NOP    = 2'd1,
    IR_EXCEPT = 2'd2
  } ir_src_t;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JMP    = 3'd2,
    PC_ILLOP  = 3'd3,
    PC_IRQ    = 3'd4,
    PC_RESET  = 3'd5
  } pc_sel_t;

  typedef enum logic [1:0] {
    BYP_RF   = 2'd0,
    BYP_EXEC = 2'd1,
    BYP_MEM  = 2'd2,
    BYP_WB   = 2'd3
  } byp_t;

  fsm_t                   fsm_q;
  logic                   irq_pend_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic    mem_busy;
  logic    freeze;
  logic    load_use;
  logic    irq_take;
  logic    stall_if_c;
  logic    stall_dec_c;
  logic    stall_exec_c;
  logic    stall_mem_c;
  ir_src_t ir_dec_c;
  ir_src_t ir_exec_c;
  pc_sel_t pc_sel_c;
  byp_t    byp_a_c;
  byp_t    byp_b_c;

  // True when a decode source port actually consumes register r.
  function automatic logic reads_reg(
    input logic [4:0] r,
    input logic [4:0] ra,
    input logic       use_a,
    input logic [4:0] rb,
    input logic       use_b
  );
    logic hit;
    hit = 1'b0;
    if (r != NREG_ZERO) begin
      hit = (use_a && (ra == r)) || (use_b && (rb == r));
    end
    return hit;
  endfunction

  // Loads are skipped as sources: their data is not ready, and load_use stalls instead.
  function automatic byp_t bypass_for(
    input logic       used,
    input logic [4:0] idx,
    input logic [4:0] x_rc,
    input logic       x_wr,
    input logic       x_ld,
    input logic [4:0] m_rc,
    input logic       m_wr,
    input logic       m_ld,
    input logic [4:0] w_rc,
    input logic       w_wr
  );
    byp_t sel;
    sel = BYP_RF;
    if (used && (idx != NREG_ZERO)) begin
      if (x_wr && !x_ld && (x_rc == idx)) begin
        sel = BYP_EXEC;
      end else if (m_wr && !m_ld && (m_rc == idx)) begin
        sel = BYP_MEM;
      end else if (w_wr && (w_rc == idx)) begin
        sel = BYP_WB;
      end
    end
    return sel;
  endfunction

  // The memory stall is seen combinationally in its first cycle, before the FSM has moved.
  assign mem_busy = bus.mem_is_memop && !bus.dmem_ready;
  assign freeze   = (fsm_q == MWAIT) || mem_busy;

  assign load_use =
      (bus.exec_is_ld && reads_reg(bus.exec_rc, bus.dec_ra, bus.dec_use_a, bus.dec_rb, bus.dec_use_b)) ||
      (bus.mem_is_ld  && reads_reg(bus.mem_rc,  bus.dec_ra, bus.dec_use_a, bus.dec_rb, bus.dec_use_b));

  always_comb begin
    stall_if_c   = 1'b0;
    stall_dec_c  = 1'b0;
    stall_exec_c = 1'b0;
    stall_mem_c  = 1'b0;
    ir_dec_c     = IR_DATA;
    ir_exec_c    = IR_DATA;
    pc_sel_c     = PC_NEXT;
    irq_take     = 1'b0;
    byp_a_c      = BYP_RF;
    byp_b_c      = BYP_RF;

    if (rst) begin
      ir_dec_c  = IR_NOP;
      ir_exec_c = IR_NOP;
      pc_sel_c  = PC_RESET;
    end else begin
      byp_a_c = bypass_for(bus.dec_use_a, bus.dec_ra,
                           bus.exec_rc, bus.exec_wr, bus.exec_is_ld,
                           bus.mem_rc, bus.mem_wr, bus.mem_is_ld,
                           bus.wb_rc, bus.wb_wr);
      byp_b_c = bypass_for(bus.dec_use_b, bus.dec_rb,
                           bus.exec_rc, bus.exec_wr, bus.exec_is_ld,
                           bus.mem_rc, bus.mem_wr, bus.mem_is_ld,
                           bus.wb_rc, bus.wb_wr);

      if (freeze) begin
        stall_if_c   = 1'b1;
        stall_dec_c  = 1'b1;
        stall_exec_c = 1'b1;
        stall_mem_c  = 1'b1;
      end else if (load_use) begin
        stall_if_c  = 1'b1;
        stall_dec_c = 1'b1;
        ir_exec_c   = IR_NOP;
      end else if (bus.dec_illop) begin
        ir_exec_c = IR_EXCEPT;
        ir_dec_c  = IR_NOP;
        pc_sel_c  = PC_ILLOP;
      end else if (irq_pend_q && !bus.pc_super) begin
        ir_exec_c = IR_EXCEPT;
        ir_dec_c  = IR_NOP;
        pc_sel_c  = PC_IRQ;
        irq_take  = 1'b1;
      end else if (bus.dec_branch_taken) begin
        ir_dec_c = IR_NOP;
        pc_sel_c = PC_BRANCH;
      end else if (bus.dec_jmp) begin
        ir_dec_c = IR_NOP;
        pc_sel_c = PC_JMP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= RUN;
      irq_pend_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (fsm_q == RUN) begin
        if (mem_busy) begin
          fsm_q <= MWAIT;
        end
      end else if (bus.dmem_ready) begin
        fsm_q <= RUN;
      end

      if (irq_take) begin
        irq_pend_q <= 1'b0;
      end else if (bus.irq) begin
        irq_pend_q <= 1'b1;
      end

      if (stall_if_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_if     = stall_if_c;
  assign bus.stall_dec    = stall_dec_c;
  assign bus.stall_exec   = stall_exec_c;
  assign bus.stall_mem    = stall_mem_c;
  assign bus.ir_src_dec   = ir_dec_c;
  assign bus.ir_src_exec  = ir_exec_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.bypass_a_sel = byp_a_c;
  assign bus.bypass_b_sel = byp_b_c;
  assign bus.irq_ack      = irq_take;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a behavioural priority model.
module tb_pipe_ctrl;

  localparam int unsigned CW = 16;
  localparam int CNT_MAX = 65535;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.STALL_CNT_W(CW)) bus ();

  pipe_ctrl #(
    .STALL_CNT_W(CW),
    .NREG_ZERO  (5'd31)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: waiting on memory, interrupt pending, stall count.
  bit m_wait, m_pend;
  int m_cnt;
  bit n_wait, n_pend;
  int n_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit uses(input int r);
    return (r != 31) && ((bus.dec_use_a && int'(bus.dec_ra) == r) ||
                         (bus.dec_use_b && int'(bus.dec_rb) == r));
  endfunction

  // Youngest non-load writer of idx wins; stages listed youngest first.
  function automatic int byp_model(input bit used, input int idx);
    int rc[3];
    bit wr[3];
    bit ld[3];
    rc = '{int'(bus.exec_rc), int'(bus.mem_rc), int'(bus.wb_rc)};
    wr = '{bus.exec_wr, bus.mem_wr, bus.wb_wr};
    ld = '{bus.exec_is_ld, bus.mem_is_ld, 1'b0};
    if (!used || idx == 31) return 0;
    for (int s = 0; s < 3; s++) begin
      if (wr[s] && !ld[s] && rc[s] == idx) return s + 1;
    end
    return 0;
  endfunction

  task automatic eval();
    int e_sif, e_sdec, e_sex, e_smem, e_irdec, e_irex, e_pc, e_ack, e_ba, e_bb;
    bit busy, frz, haz, inj;
    #1;
    e_sif = 0; e_sdec = 0; e_sex = 0; e_smem = 0;
    e_irdec = 0; e_irex = 0; e_pc = 0; e_ack = 0; e_ba = 0; e_bb = 0;
    haz = 0;
    if (rst) begin
      e_pc = 5; e_irdec = 1; e_irex = 1;
      n_wait = 0; n_pend = 0; n_cnt = 0;
    end else begin
      busy = bus.mem_is_memop && !bus.dmem_ready;
      frz  = m_wait || busy;
      haz  = (bus.exec_is_ld && uses(int'(bus.exec_rc))) ||
             (bus.mem_is_ld  && uses(int'(bus.mem_rc)));
      inj  = 0;
      if (frz) begin
        e_sif = 1; e_sdec = 1; e_sex = 1; e_smem = 1;
      end else if (haz) begin
        e_sif = 1; e_sdec = 1; e_irex = 1;
      end else if (bus.dec_illop) begin
        e_irex = 2; e_irdec = 1; e_pc = 3;
      end else if (m_pend && !bus.pc_super) begin
        e_irex = 2; e_irdec = 1; e_pc = 4; e_ack = 1; inj = 1;
      end else if (bus.dec_branch_taken) begin
        e_irdec = 1; e_pc = 1;
      end else if (bus.dec_jmp) begin
        e_irdec = 1; e_pc = 2;
      end
      e_ba = byp_model(bus.dec_use_a, int'(bus.dec_ra));
      e_bb = byp_model(bus.dec_use_b, int'(bus.dec_rb));
      n_wait = frz && !bus.dmem_ready;
      n_pend = inj ? 1'b0 : (m_pend || bus.irq);
      n_cnt  = (m_cnt + e_sif > CNT_MAX) ? CNT_MAX : m_cnt + e_sif;
    end
    check("stall_if",    bus.stall_if,    e_sif);
    check("stall_dec",   bus.stall_dec,   e_sdec);
    check("stall_exec",  bus.stall_exec,  e_sex);
    check("stall_mem",   bus.stall_mem,   e_smem);
    check("ir_src_dec",  bus.ir_src_dec,  e_irdec);
    check("ir_src_exec", bus.ir_src_exec, e_irex);
    check("pc_sel",      bus.pc_sel,      e_pc);
    check("irq_ack",     bus.irq_ack,     e_ack);
    if (!haz) begin
      check("bypass_a", bus.bypass_a_sel, e_ba);
      check("bypass_b", bus.bypass_b_sel, e_bb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_wait = n_wait;
    m_pend = n_pend;
    m_cnt  = n_cnt;
    #1;
    check("stall_cnt", bus.stall_cnt, m_cnt);
  endtask

  task automatic idle();
    bus.dec_ra = 5'd0; bus.dec_rb = 5'd0; bus.dec_use_a = 0; bus.dec_use_b = 0;
    bus.dec_branch_taken = 0; bus.dec_jmp = 0; bus.dec_illop = 0;
    bus.exec_rc = 5'd0; bus.exec_wr = 0; bus.exec_is_ld = 0;
    bus.mem_rc = 5'd0; bus.mem_wr = 0; bus.mem_is_ld = 0; bus.mem_is_memop = 0;
    bus.dmem_ready = 1; bus.wb_rc = 5'd0; bus.wb_wr = 0;
    bus.irq = 0; bus.pc_super = 0;
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom % 6)
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return 5'd31;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    bus.dec_ra = rreg(); bus.dec_rb = rreg();
    bus.dec_use_a = 1'($urandom); bus.dec_use_b = 1'($urandom);
    bus.dec_branch_taken = ($urandom % 4 == 0);
    bus.dec_jmp = ($urandom % 6 == 0);
    bus.dec_illop = ($urandom % 10 == 0);
    bus.exec_rc = rreg(); bus.exec_wr = 1'($urandom); bus.exec_is_ld = ($urandom % 5 == 0);
    bus.mem_rc = rreg(); bus.mem_wr = 1'($urandom); bus.mem_is_ld = ($urandom % 5 == 0);
    bus.mem_is_memop = bus.mem_is_ld || ($urandom % 6 == 0);
    bus.dmem_ready = ($urandom % 4 != 0);
    bus.wb_rc = rreg(); bus.wb_wr = 1'($urandom);
    bus.irq = ($urandom % 8 == 0);
    bus.pc_super = ($urandom % 3 == 0);
  endtask

  initial begin
    m_wait = 0; m_pend = 0; m_cnt = 0;
    idle();

    // Reset
    rst = 1;
    eval(); check("rst_pc_sel", bus.pc_sel, 5); tick();
    eval(); tick();
    rst = 0;

    // Bypass priority and R31
    idle();
    bus.exec_rc = 5'd3; bus.exec_wr = 1; bus.mem_rc = 5'd3; bus.mem_wr = 1;
    bus.dec_ra = 5'd3; bus.dec_use_a = 1;
    eval(); check("byp_exec_over_mem", bus.bypass_a_sel, 1); tick();
    bus.dec_ra = 5'd31;
    eval(); check("byp_r31", bus.bypass_a_sel, 0); tick();

    // Load-use hides a taken branch
    idle();
    bus.exec_is_ld = 1; bus.exec_rc = 5'd5; bus.exec_wr = 1;
    bus.dec_rb = 5'd5; bus.dec_use_b = 1; bus.dec_branch_taken = 1;
    eval();
    check("lu_stall_if", bus.stall_if, 1);
    check("lu_ir_exec", bus.ir_src_exec, 1);
    check("lu_pc_sel", bus.pc_sel, 0);
    tick(); check("lu_cnt", bus.stall_cnt, 1);

    // Memory wait: three not-ready cycles then ready
    idle();
    bus.mem_is_memop = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      eval(); check("mw_stall_mem", bus.stall_mem, 1); tick();
    end
    bus.dmem_ready = 1;
    eval(); check("mw_last_frozen", bus.stall_exec, 1); tick();
    bus.mem_is_memop = 0;
    eval(); check("mw_released", bus.stall_if, 0); tick();
    check("mw_cnt", bus.stall_cnt, 5);

    // Interrupt masked by supervisor mode, then injected once
    idle();
    bus.pc_super = 1; bus.irq = 1;
    eval(); tick();
    bus.irq = 0;
    eval(); check("irq_masked", bus.irq_ack, 0); tick();
    bus.pc_super = 0;
    eval();
    check("irq_ack", bus.irq_ack, 1);
    check("irq_pc", bus.pc_sel, 4);
    check("irq_ir_exec", bus.ir_src_exec, 2);
    tick();
    eval(); check("irq_cleared", bus.irq_ack, 0); tick();

    // Illop beats a pending interrupt; interrupt follows
    bus.pc_super = 1; bus.irq = 1;
    eval(); tick();
    bus.irq = 0; bus.pc_super = 0; bus.dec_illop = 1;
    eval(); check("ill_pc", bus.pc_sel, 3); check("ill_no_ack", bus.irq_ack, 0); tick();
    bus.dec_illop = 0;
    eval(); check("ill_then_irq", bus.pc_sel, 4); tick();

    // Random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      rst = ($urandom % 200 == 0);
      eval(); tick();
    end
    rst = 0;

    // Saturation, then reset in the middle of a memory wait
    idle();
    bus.mem_is_memop = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 70000; i++) begin
      eval(); tick();
    end
    check("sat_cnt", bus.stall_cnt, 16'hFFFF);
    bus.irq = 1;
    eval(); tick();
    bus.irq = 0;
    rst = 1;
    eval(); check("rst_mw_pc", bus.pc_sel, 5); tick();
    rst = 0;
    idle();
    eval();
    check("rst_mw_run", bus.stall_if, 0);
    check("rst_irq_dropped", bus.irq_ack, 0);
    check("rst_mw_cnt", bus.stall_cnt, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
